tt_um_accum_alu: RTL and testbench

TT_UM_ACCUM_ALU -- requirements
Module: tt_um_accum_alu

---
 rtl/tt_um_accum_alu.sv | 117 +++++++++++
 tb/tb_tt_um_accum_alu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_accum_alu.sv
// Two-operand add/saturating-add unit with a small bank of per-channel
// accumulators behind a valid/ready request port and a single-entry
// output register (latency 1, full throughput).
module tt_um_accum_alu #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int CHW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [CHW-1:0]   in_ch,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CHW-1:0]   out_ch,
    output logic             out_ovf,
    output logic [15:0]      txn_count
);

    localparam logic [1:0] MODE_ADD    = 2'b00;
    localparam logic [1:0] MODE_ADDSAT = 2'b01;
    localparam logic [1:0] MODE_ACC    = 2'b10;
    localparam logic [1:0] MODE_CLR    = 2'b11;

    logic [WIDTH-1:0] acc [NCH];

    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH+1:0] acc_full;
    logic [WIDTH-1:0] res_sum;
    logic             res_ovf;
    logic             acc_we;
    logic [WIDTH-1:0] acc_new;

    // Ready whenever the output slot is free or being drained this cycle;
    // reset and a low enable both block new requests.
    assign in_ready = ena && !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Result and accumulator-update computation for the request on the inputs.
    always_comb begin
        add_full = {1'b0, in_a} + {1'b0, in_b};
        acc_full = {2'b00, acc[in_ch]} + {2'b00, in_a} + {2'b00, in_b};
        res_sum  = '0;
        res_ovf  = 1'b0;
        acc_we   = 1'b0;
        acc_new  = '0;
        unique case (in_mode)
            MODE_ADD: begin
                res_sum = add_full[WIDTH-1:0];
                res_ovf = add_full[WIDTH];
            end
            MODE_ADDSAT: begin
                res_sum = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
                res_ovf = add_full[WIDTH];
            end
            MODE_ACC: begin
                res_sum = acc_full[WIDTH-1:0];
                res_ovf = |acc_full[WIDTH+1:WIDTH];
                acc_we  = 1'b1;
                acc_new = acc_full[WIDTH-1:0];
            end
            MODE_CLR: begin
                acc_we  = 1'b1;
                acc_new = '0;
            end
            default: begin
                res_sum = '0;
            end
        endcase
    end

    // Output register: load on accept, drop when drained, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ch    <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= res_sum;
            out_ch    <= in_ch;
            out_ovf   <= res_ovf;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulators are written on the accept edge so a back-to-back request
    // on the same channel sees the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
        end else if (accept && acc_we) begin
            acc[in_ch] <= acc_new;
        end
    end

    // Accepted-request counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_count <= '0;
        end else if (accept && (txn_count != 16'hFFFF)) begin
            txn_count <= txn_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_tt_um_accum_alu.sv
// Scoreboard bench for tt_um_accum_alu: a driver applies directed and random
// requests and pushes reference results; a monitor pops them as the DUT
// hands results to the consumer.
module tb_tt_um_accum_alu;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int MAXV  = 1 << WIDTH;
    localparam int M_ADD = 0, M_SAT = 1, M_ACC = 2, M_CLR = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [CHW-1:0]   in_ch = '0;
    logic [1:0]       in_mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic [CHW-1:0]   out_ch;
    logic             out_ovf;
    logic [15:0]      txn_count;

    always #5 clk = ~clk;

    tt_um_accum_alu #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ch(in_ch), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ch(out_ch), .out_ovf(out_ovf),
        .txn_count(txn_count)
    );

    typedef struct {
        int sum;
        int ch;
        int ovf;
    } res_t;

    res_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state: accumulator values, pending-result flag, request count.
    int   m_acc[NCH];
    bit   m_ov = 1'b0;
    int   m_cnt_raw = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One clock of stimulus; the model decides acceptance on its own.
    task automatic cycle(input bit r, input bit e, input bit v, input bit ordy,
                         input int a, input int b, input int ch, input int md);
        res_t item;
        bit   exp_rdy;
        bit   nov;
        int   s;
        @(negedge clk);
        rst = r; ena = e; in_valid = v; out_ready = ordy;
        in_a = a[WIDTH-1:0]; in_b = b[WIDTH-1:0];
        in_ch = ch[CHW-1:0]; in_mode = md[1:0];
        #1;
        exp_rdy = !r && e && (!m_ov || ordy);
        checks++;
        if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL in_ready: got %0b expected %0b", in_ready, exp_rdy);
        end
        if (r) begin
            nov = 1'b0;
            foreach (m_acc[i]) m_acc[i] = 0;
            m_cnt_raw = 0;
            sbq.delete();
        end else if (v && exp_rdy) begin
            item.ch = ch;
            s = a + b;
            case (md)
                M_ADD: begin item.sum = s % MAXV; item.ovf = (s >= MAXV); end
                M_SAT: begin item.sum = (s >= MAXV) ? MAXV - 1 : s; item.ovf = (s >= MAXV); end
                M_ACC: begin
                    s = m_acc[ch] + a + b;
                    m_acc[ch] = s % MAXV;
                    item.sum = s % MAXV;
                    item.ovf = (s >= MAXV);
                end
                default: begin m_acc[ch] = 0; item.sum = 0; item.ovf = 0; end
            endcase
            sbq.push_back(item);
            m_cnt_raw++;
            nov = 1'b1;
        end else if (m_ov && ordy) begin
            nov = 1'b0;
        end else begin
            nov = m_ov;
        end
        @(posedge clk);
        m_ov  = nov;
        m_cnt = (m_cnt_raw > 65535) ? 65535 : m_cnt_raw;
        #1;
    endtask

    // Monitor: checks handshake state each cycle, pops on consumption,
    // and checks that a stalled result does not move.
    initial begin
        res_t exp;
        bit   held = 1'b0;
        int   h_sum, h_ch, h_ovf;
        forever begin
            @(negedge clk);
            #2;
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("txn_count", int'(txn_count), m_cnt);
            if (held) begin
                checks++;
                if (out_sum != h_sum[WIDTH-1:0] || out_ch != h_ch[CHW-1:0] || out_ovf != h_ovf[0]) begin
                    failures++;
                    $display("FAIL hold: got sum=%0d ch=%0d ovf=%0b expected sum=%0d ch=%0d ovf=%0d",
                             out_sum, out_ch, out_ovf, h_sum, h_ch, h_ovf);
                end
            end
            held = 1'b0;
            if (!rst && out_valid === 1'b1) begin
                if (out_ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL result: got sum=%0d with no expected result pending", out_sum);
                    end else begin
                        exp = sbq.pop_front();
                        if (out_sum != exp.sum[WIDTH-1:0] || out_ch != exp.ch[CHW-1:0] || out_ovf != exp.ovf[0]) begin
                            failures++;
                            $display("FAIL result: got sum=%0d ch=%0d ovf=%0b expected sum=%0d ch=%0d ovf=%0d",
                                     out_sum, out_ch, out_ovf, exp.sum, exp.ch, exp.ovf);
                        end
                    end
                end else begin
                    held = 1'b1;
                    h_sum = int'(out_sum);
                    h_ch  = int'(out_ch);
                    h_ovf = int'(out_ovf);
                end
            end
        end
    end

    // Driver: directed scenarios, random stream, then saturation run.
    initial begin
        int saved_cnt;
        int guard;
        foreach (m_acc[i]) m_acc[i] = 0;

        cycle(1, 1, 0, 0, 0, 0, 0, M_ADD);
        cycle(1, 1, 1, 1, 3, 3, 1, M_ACC);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_ch", int'(out_ch), 0);
        chk("rst_ovf", int'(out_ovf), 0);
        chk("rst_cnt", int'(txn_count), 0);

        cycle(0, 1, 1, 1, 200, 100, 0, M_ADD);
        chk("add_valid", int'(out_valid), 1);
        chk("add_sum", int'(out_sum), 44);
        chk("add_ovf", int'(out_ovf), 1);
        cycle(0, 1, 1, 1, 200, 100, 0, M_SAT);
        chk("sat_sum", int'(out_sum), 255);
        chk("sat_ovf", int'(out_ovf), 1);

        cycle(0, 1, 1, 1, 100, 50, 1, M_ACC);
        chk("acc1_sum", int'(out_sum), 150);
        chk("acc1_ovf", int'(out_ovf), 0);
        cycle(0, 1, 1, 1, 100, 10, 1, M_ACC);
        chk("acc1b_sum", int'(out_sum), 4);
        chk("acc1b_ovf", int'(out_ovf), 1);
        cycle(0, 1, 1, 1, 0, 0, 0, M_ACC);
        chk("acc0_sum", int'(out_sum), 0);

        cycle(0, 1, 1, 1, 70, 7, 2, M_ACC);
        chk("acc2_sum", int'(out_sum), 77);
        cycle(0, 1, 1, 1, 9, 9, 2, M_CLR);
        chk("clr2_sum", int'(out_sum), 0);
        cycle(0, 1, 1, 1, 1, 2, 2, M_ACC);
        chk("acc2c_sum", int'(out_sum), 3);

        saved_cnt = int'(txn_count);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 5, 6, 3, M_ADD);
        chk("stall_sum", int'(out_sum), 3);
        chk("stall_cnt", int'(txn_count), saved_cnt);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 5 + i, 6, 3, M_ACC);
        chk("resume_sum", int'(out_sum), 5 + 6 + 6 + 6 + 6 + 6 + 7 + 8);

        cycle(0, 0, 1, 0, 1, 1, 0, M_ADD);
        cycle(0, 0, 1, 1, 1, 1, 0, M_ADD);
        chk("ena_drain", int'(out_valid), 0);

        cycle(0, 1, 1, 1, 20, 20, 1, M_ACC);
        cycle(1, 1, 1, 1, 20, 20, 1, M_ACC);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_cnt", int'(txn_count), 0);
        for (int c = 0; c < NCH; c++) begin
            cycle(0, 1, 1, 1, 0, 0, c, M_ACC);
            chk("midrst_acc", int'(out_sum), 0);
        end

        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, MAXV - 1), $urandom_range(0, MAXV - 1),
                  $urandom_range(0, NCH - 1), $urandom_range(0, 3));
        end

        guard = 0;
        while (m_cnt_raw < 70000 && guard < 80000) begin
            cycle(0, 1, 1, 1, $urandom_range(0, MAXV - 1), $urandom_range(0, MAXV - 1),
                  $urandom_range(0, NCH - 1), $urandom_range(0, 3));
            guard++;
        end
        chk("stream_len", m_cnt_raw >= 70000, 1);

        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 0, 0, 0, M_ADD);
        chk("drain_empty", sbq.size(), 0);
        chk("cnt_sat", int'(txn_count), 65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
